// File: rtl/proc_cpu_mul_pipe_if.sv
// Operand/result bundle between the E-stage issue logic and the pipelined multiplier.
// The issuing side is the master; the multiplier is the slave.
interface proc_cpu_mul_pipe_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] E_src1;
  logic [DATA_W-1:0] E_src2;
  logic [1:0]        E_mode;
  logic              E_valid;
  logic              M_en;
  logic              M_flush;
  logic [DATA_W-1:0] M_result;
  logic              M_valid;
  logic              M_busy;

  modport master (
    output E_src1, E_src2, E_mode, E_valid, M_en, M_flush,
    input  M_result, M_valid, M_busy
  );

  modport slave (
    input  E_src1, E_src2, E_mode, E_valid, M_en, M_flush,
    output M_result, M_valid, M_busy
  );
endinterface

// File: rtl/proc_cpu_mul_pipe.sv
// Stallable, flushable pipelined multiplier: half-width partial products, then the
// carry-preserving sum with signed-mode correction of the high half.
module proc_cpu_mul_pipe #(
  parameter int DATA_W      = 32,
  parameter int PIPE_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  proc_cpu_mul_pipe_if.slave   bus
);
  localparam int HALF_W = DATA_W / 2;
  // Internal stages sit in front of the registered output stage.
  localparam int NI     = PIPE_STAGES - 1;

  typedef struct packed {
    logic [1:0]        mode;
    logic [DATA_W-1:0] corr;
    logic [DATA_W-1:0] p_hh;
    logic [DATA_W-1:0] p_hl;
    logic [DATA_W-1:0] p_lh;
    logic [DATA_W-1:0] p_ll;
  } stage_t;

  logic [HALF_W-1:0] a_lo, a_hi, b_lo, b_hi;
  stage_t            stage1_next;
  logic [NI-1:0]     stage_valid;

  assign a_lo = bus.E_src1[HALF_W-1:0];
  assign a_hi = bus.E_src1[DATA_W-1:HALF_W];
  assign b_lo = bus.E_src2[HALF_W-1:0];
  assign b_hi = bus.E_src2[DATA_W-1:HALF_W];

  // The signed-mode correction term is formed early so the operands need not travel.
  always_comb begin
    stage1_next      = '0;
    stage1_next.mode = bus.E_mode;
    stage1_next.p_ll = DATA_W'(a_lo) * DATA_W'(b_lo);
    stage1_next.p_lh = DATA_W'(a_lo) * DATA_W'(b_hi);
    stage1_next.p_hl = DATA_W'(a_hi) * DATA_W'(b_lo);
    stage1_next.p_hh = DATA_W'(a_hi) * DATA_W'(b_hi);
    if (bus.E_mode[1] && bus.E_src1[DATA_W-1]) begin
      stage1_next.corr = bus.E_src2;
    end
    if (bus.E_mode == 2'b11 && bus.E_src2[DATA_W-1]) begin
      stage1_next.corr = stage1_next.corr + bus.E_src1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_stage
      stage_t data_in;
      logic   valid_in;
      stage_t data_reg;
      logic   valid_reg;

      if (gi == 0) begin : g_first
        assign data_in  = stage1_next;
        assign valid_in = bus.E_valid;
      end else begin : g_chain
        assign data_in  = g_stage[gi-1].data_reg;
        assign valid_in = g_stage[gi-1].valid_reg;
      end

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          data_reg  <= '0;
          valid_reg <= 1'b0;
        end else begin
          // Flush only kills valid bits; data keeps following the enable.
          if (bus.M_flush) begin
            valid_reg <= 1'b0;
          end else if (bus.M_en) begin
            valid_reg <= valid_in;
          end
          if (bus.M_en) begin
            data_reg <= data_in;
          end
        end
      end

      assign stage_valid[gi] = valid_reg;
    end
  endgenerate

  stage_t              last;
  logic                last_valid;
  logic [DATA_W:0]     mid;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   hi;
  logic [DATA_W-1:0]   result_next;
  logic [DATA_W-1:0]   result_reg;
  logic                valid_reg;

  assign last       = g_stage[NI-1].data_reg;
  assign last_valid = g_stage[NI-1].valid_reg;

  always_comb begin
    mid  = {1'b0, last.p_lh} + {1'b0, last.p_hl};
    prod = (2*DATA_W)'(last.p_ll)
         + ((2*DATA_W)'(mid) << HALF_W)
         + {last.p_hh, {DATA_W{1'b0}}};
    hi   = prod[2*DATA_W-1:DATA_W] - last.corr;
    result_next = (last.mode == 2'b00) ? prod[DATA_W-1:0] : hi;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      result_reg <= '0;
      valid_reg  <= 1'b0;
    end else begin
      if (bus.M_flush) begin
        valid_reg <= 1'b0;
      end else if (bus.M_en) begin
        valid_reg <= last_valid;
      end
      if (bus.M_en) begin
        result_reg <= result_next;
      end
    end
  end

  assign bus.M_result = result_reg;
  assign bus.M_valid  = valid_reg;
  assign bus.M_busy   = |stage_valid;
endmodule

// File: tb/tb_proc_cpu_mul_pipe.sv
// Directed and random checks of two multiplier configurations (32-bit/2-stage and
// 16-bit/4-stage) sharing control stimulus, against an in-flight-list product model.
module tb_proc_cpu_mul_pipe;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] src1, src2;
  logic [1:0]  mode;
  logic        valid, en, flush;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  proc_cpu_mul_pipe_if #(.DATA_W(32)) bus0 ();
  proc_cpu_mul_pipe_if #(.DATA_W(16)) bus1 ();

  assign bus0.E_src1  = src1;
  assign bus0.E_src2  = src2;
  assign bus0.E_mode  = mode;
  assign bus0.E_valid = valid;
  assign bus0.M_en    = en;
  assign bus0.M_flush = flush;
  assign bus1.E_src1  = src1[15:0];
  assign bus1.E_src2  = src2[15:0];
  assign bus1.E_mode  = mode;
  assign bus1.E_valid = valid;
  assign bus1.M_en    = en;
  assign bus1.M_flush = flush;

  proc_cpu_mul_pipe #(.DATA_W(32), .PIPE_STAGES(2)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0));
  proc_cpu_mul_pipe #(.DATA_W(16), .PIPE_STAGES(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1));

  // Reference: full product of the sign/zero-extended operands, then pick a half.
  function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                          input logic [1:0] m, input int w);
    logic [63:0]  mask;
    logic [127:0] ea, eb, p, sh;
    mask = (64'd1 << w) - 64'd1;
    ea = {64'd0, a & mask};
    eb = {64'd0, b & mask};
    if (m[1] && a[w-1]) ea = ea | ~{64'd0, mask};
    if (m == 2'b11 && b[w-1]) eb = eb | ~{64'd0, mask};
    p = ea * eb;
    if (m == 2'b00) return p[63:0] & mask;
    sh = p >> w;
    return sh[63:0] & mask;
  endfunction

  // Model: list of in-flight ops, each with the number of enabled edges still to go.
  int          cnt[2];
  int          mrem[2][8];
  logic [63:0] mval[2][8];
  bit          ev[2];
  logic [63:0] er[2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int w, ps;
      w  = (d == 0) ? 32 : 16;
      ps = (d == 0) ? 2 : 4;
      if (!reset_n) begin
        cnt[d] = 0;
        ev[d]  = 1'b0;
        er[d]  = 64'd0;
      end else if (flush) begin
        cnt[d] = 0;
        ev[d]  = 1'b0;
      end else if (en) begin
        ev[d] = 1'b0;
        for (int i = 0; i < cnt[d]; i++) mrem[d][i] = mrem[d][i] - 1;
        if (cnt[d] > 0 && mrem[d][0] == 0) begin
          ev[d] = 1'b1;
          er[d] = mval[d][0];
          for (int i = 0; i < cnt[d] - 1; i++) begin
            mrem[d][i] = mrem[d][i+1];
            mval[d][i] = mval[d][i+1];
          end
          cnt[d] = cnt[d] - 1;
        end
        if (valid) begin
          mval[d][cnt[d]] = ref_mul({32'd0, src1}, {32'd0, src2}, mode, w);
          mrem[d][cnt[d]] = ps - 1;
          cnt[d] = cnt[d] + 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp, input bit verbose);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else if (verbose) begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("d0 valid", 64'(bus0.M_valid), 64'(ev[0]), 1'b0);
      check("d0 busy",  64'(bus0.M_busy),  64'(cnt[0] != 0), 1'b0);
      if (ev[0]) check("d0 result", 64'(bus0.M_result), er[0], 1'b0);
      check("d1 valid", 64'(bus1.M_valid), 64'(ev[1]), 1'b0);
      check("d1 busy",  64'(bus1.M_busy),  64'(cnt[1] != 0), 1'b0);
      if (ev[1]) check("d1 result", 64'(bus1.M_result), er[1], 1'b0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
    src1  = a;
    src2  = b;
    mode  = m;
    valid = 1'b1;
  endtask

  logic [31:0] va[5], vb[5], vexp[5];
  logic [1:0]  vm[5];
  int          ops;

  initial begin
    va = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    vb = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    vm = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b11};
    vexp = '{32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h4000_0000};

    reset_n = 1'b0; en = 1'b0; flush = 1'b0; valid = 1'b0;
    src1 = '0; src2 = '0; mode = 2'b00;
    step();
    step();
    chk_on = 1'b1;
    check("reset valid",  64'(bus0.M_valid),  64'd0, 1'b1);
    check("reset busy",   64'(bus0.M_busy),   64'd0, 1'b1);
    check("reset result", 64'(bus0.M_result), 64'd0, 1'b1);
    reset_n = 1'b1;
    en = 1'b1;

    // Basic low/high results and two-edge latency.
    issue(32'h0001_0002, 32'h0003_0004, 2'b00);
    step();
    check("t1 not yet valid", 64'(bus0.M_valid), 64'd0, 1'b1);
    issue(32'h0001_0002, 32'h0003_0004, 2'b01);
    step();
    check("t1 mul valid", 64'(bus0.M_valid), 64'd1, 1'b1);
    check("t1 mul lo", 64'(bus0.M_result), 64'h0000_0000_000A_0008, 1'b1);
    valid = 1'b0;
    step();
    check("t1 mulxuu valid", 64'(bus0.M_valid), 64'd1, 1'b1);
    check("t1 mulxuu hi", 64'(bus0.M_result), 64'h0000_0000_0000_0003, 1'b1);
    step();
    check("t1 drained", 64'(bus0.M_valid), 64'd0, 1'b1);

    // Back-to-back corner operands in every mode.
    for (int j = 0; j <= 5; j++) begin
      if (j < 5) issue(va[j], vb[j], vm[j]);
      else valid = 1'b0;
      step();
      if (j >= 1) begin
        check($sformatf("t23 op%0d valid", j - 1), 64'(bus0.M_valid), 64'd1, 1'b1);
        check($sformatf("t23 op%0d mode%0d", j - 1, vm[j-1]), 64'(bus0.M_result),
              {32'd0, vexp[j-1]}, 1'b1);
      end
    end
    step();
    check("t23 drained", 64'(bus0.M_valid), 64'd0, 1'b1);

    // Stall mid-flight: output frozen, next result three cycles late.
    issue(32'd7, 32'd6, 2'b00);
    step();
    issue(32'h1234_5678, 32'h0000_0010, 2'b00);
    step();
    check("t4 first result", 64'(bus0.M_result), 64'h2A, 1'b1);
    valid = 1'b0;
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("t4 stall%0d valid", k), 64'(bus0.M_valid), 64'd1, 1'b1);
      check($sformatf("t4 stall%0d result", k), 64'(bus0.M_result), 64'h2A, 1'b1);
      check($sformatf("t4 stall%0d busy", k), 64'(bus0.M_busy), 64'd1, 1'b1);
    end
    en = 1'b1;
    step();
    check("t4 late valid", 64'(bus0.M_valid), 64'd1, 1'b1);
    check("t4 late result", 64'(bus0.M_result), 64'h2345_6780, 1'b1);
    step();

    // Flush with ops in flight and a new op arriving.
    issue(32'd3, 32'd5, 2'b00);
    step();
    issue(32'd4, 32'd5, 2'b00);
    step();
    issue(32'd6, 32'd5, 2'b00);
    flush = 1'b1;
    step();
    flush = 1'b0;
    valid = 1'b0;
    check("t5 flush valid", 64'(bus0.M_valid), 64'd0, 1'b1);
    check("t5 flush busy", 64'(bus0.M_busy), 64'd0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("t5 no result %0d", k), 64'(bus0.M_valid), 64'd0, 1'b1);
    end

    // Reset with both pipes full and stalled.
    for (int k = 0; k < 4; k++) begin
      issue(32'h9000_0001 + k, 32'hC000_0003, 2'b11);
      step();
    end
    valid = 1'b0;
    en = 1'b0;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("t6 d0 valid", 64'(bus0.M_valid), 64'd0, 1'b1);
    check("t6 d0 busy", 64'(bus0.M_busy), 64'd0, 1'b1);
    check("t6 d0 result", 64'(bus0.M_result), 64'd0, 1'b1);
    check("t6 d1 valid", 64'(bus1.M_valid), 64'd0, 1'b1);
    check("t6 d1 busy", 64'(bus1.M_busy), 64'd0, 1'b1);
    check("t6 d1 result", 64'(bus1.M_result), 64'd0, 1'b1);

    // Random ops with random stalls, flushes and rare resets.
    ops = 0;
    for (int c = 0; c < 40000 && ops < 10000; c++) begin
      en      = ($urandom_range(3) != 0);
      flush   = ($urandom_range(40) == 0);
      reset_n = ($urandom_range(999) != 0);
      valid   = ($urandom_range(4) != 0);
      mode    = 2'($urandom_range(3));
      case ($urandom_range(4))
        0: src1 = 32'h8000_8000;
        1: src1 = 32'hFFFF_FFFF;
        default: src1 = $urandom();
      endcase
      case ($urandom_range(4))
        0: src2 = 32'h0000_8000;
        1: src2 = 32'hFFFF_FFFF;
        default: src2 = $urandom();
      endcase
      if (valid && en && !flush && reset_n) ops++;
      step();
    end
    reset_n = 1'b1;
    flush = 1'b0;
    valid = 1'b0;
    en = 1'b1;
    repeat (6) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
